// File: rtl/vedic_pkg.sv
// Shared constants for the sequential vedic multiplier: state encoding and digit helpers.
package vedic_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int digit_count(input int width);
        return width / 2;
    endfunction

    // A single-digit operand still needs a 1-bit index register.
    function automatic int idx_width(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

endpackage

// File: rtl/vedic2bit.sv
// Combinational 2x2 vedic (Urdhva Tiryagbhyam) multiplier core.
module vedic2bit (
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic [3:0] M
);

    logic cross_hi;
    logic cross_lo;
    logic carry;
    logic top;

    assign cross_hi = A[1] & B[0];
    assign cross_lo = A[0] & B[1];
    assign carry    = cross_hi & cross_lo;
    assign top      = A[1] & B[1];

    assign M[0] = A[0] & B[0];
    assign M[1] = cross_hi ^ cross_lo;
    assign M[2] = top ^ carry;
    assign M[3] = top & carry;

endmodule

// File: rtl/vedic_seq_mult_ctrl.sv
// Iterative WIDTHxWIDTH unsigned multiplier: one 2-bit digit pair per cycle through a shared 2x2 core.
module vedic_seq_mult_ctrl
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int D  = digit_count(WIDTH);
    localparam int IW = idx_width(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [IW-1:0]    i_idx;
    logic [IW-1:0]    j_idx;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [1:0]       a_dig;
    logic [1:0]       b_dig;
    logic [3:0]       m;
    logic [IW:0]      dig_sum;
    logic [PW-1:0]    pp;
    logic             accept;
    logic             last_pair;

    assign accept    = (state == ST_IDLE) && in_valid;
    assign last_pair = (i_idx == LAST) && (j_idx == LAST);

    assign a_dig = 2'(a_lat >> {i_idx, 1'b0});
    assign b_dig = 2'(b_lat >> {j_idx, 1'b0});

    vedic2bit u_core (
        .A (a_dig),
        .B (b_dig),
        .M (m)
    );

    // Partial product weight is 4^(i+j); the sum needs one extra bit of headroom.
    assign dig_sum = {1'b0, i_idx} + {1'b0, j_idx};
    assign pp      = PW'(m) << {dig_sum, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)    state_next = ST_RUN;
            ST_RUN:  if (last_pair) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_RUN) || (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_idx   <= '0;
            j_idx   <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_lat   <= a;
                        b_lat   <= b;
                        product <= '0;
                        i_idx   <= '0;
                        j_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    product <= product + pp;
                    if (j_idx == LAST) begin
                        j_idx <= '0;
                        i_idx <= (i_idx == LAST) ? '0 : i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
